// File: rtl/enemy_bullet_pkg.sv
// Shared types and constants for the enemy bullet pool sequencer.
// Spawn offsets are relative to the enemy plane's top-left corner.
package enemy_bullet_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    SPAWN = 2'd2
  } state_e;

  typedef struct packed {
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
  } slot_t;

  localparam int          SPAWN_DX         = 23;
  localparam int          SPAWN_DY         = 40;
  localparam logic [11:0] BULLET_RGB       = 12'h0F0;
  localparam int          SCREEN_H_DEFAULT = 480;

endpackage

// File: rtl/enemy_bullet_scheduler_match.sv
// Purpose: combinational test of whether the scan pixel lies inside one bullet rectangle.
// Latency: 0 cycles. Backpressure: none, pure function of its inputs.
// 11-bit compares so a bullet near x/y=1023 cannot wrap its far edge back to 0.
module bullet_pixel_match #(
  parameter int BULLET_W = 4,
  parameter int BULLET_H = 16
) (
  input  logic       active_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  input  logic [9:0] pix_x_i,
  input  logic [9:0] pix_y_i,
  output logic       match_o
);

  logic [10:0] px, py, bx, by;

  assign px = {1'b0, pix_x_i};
  assign py = {1'b0, pix_y_i};
  assign bx = {1'b0, x_i};
  assign by = {1'b0, y_i};

  assign match_o = active_i
                && (px >= bx) && (px < bx + 11'(BULLET_W))
                && (py >= by) && (py < by + 11'(BULLET_H));

endmodule

// File: rtl/enemy_bullet_scheduler.sv
// Purpose: owns the enemy bullet pool; one walk per tick moves every slot, then tries a spawn.
// Latency: walk takes NUM_SLOTS+1 cycles after the tick; pixel enable is 1 cycle registered.
// Backpressure: a tick during a walk is held one-deep; extra ticks while pending are dropped.
module enemy_bullet_scheduler
  import enemy_bullet_pkg::*;
#(
  parameter int NUM_SLOTS     = 4,
  parameter int FIRE_INTERVAL = 60,
  parameter int SPEED         = 2,
  parameter int SCREEN_H      = SCREEN_H_DEFAULT,
  parameter int BULLET_W      = 4,
  parameter int BULLET_H      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick,
  input  logic [9:0]                   ep_x,
  input  logic [9:0]                   ep_y,
  input  logic                         enemy_alive,
  input  logic                         hit_valid,
  input  logic [$clog2(NUM_SLOTS)-1:0] hit_slot,
  input  logic [9:0]                   pix_x,
  input  logic [9:0]                   pix_y,
  output logic [10*NUM_SLOTS-1:0]      eb_x_flat,
  output logic [10*NUM_SLOTS-1:0]      eb_y_flat,
  output logic [NUM_SLOTS-1:0]         eb_active,
  output logic                         fire_pulse,
  output logic                         busy,
  output logic                         enemy_bullet_en,
  output logic [11:0]                  enemy_bullet_rgb
);

  localparam int IW = $clog2(NUM_SLOTS);
  localparam int CW = $clog2(FIRE_INTERVAL + 1);

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           pend_q, pend_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           fire_q, fire_d;
  logic           en_q;
  logic [11:0]    rgb_q;
  slot_t          slot_q [NUM_SLOTS];
  slot_t          slot_d [NUM_SLOTS];

  logic [10:0]    ny;
  logic           free_found;
  logic [IW-1:0]  free_idx;
  logic [NUM_SLOTS-1:0] match;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    fire_d     = 1'b0;
    ny         = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) slot_d[i] = slot_q[i];

    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!free_found && !slot_q[i].active) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end

    case (state_q)
      IDLE: begin
        if (tick || pend_q) begin
          state_d = MOVE;
          idx_d   = '0;
          pend_d  = 1'b0;
        end
      end
      MOVE: begin
        if (tick) pend_d = 1'b1;
        if (slot_q[idx_q].active) begin
          ny = {1'b0, slot_q[idx_q].y} + 11'(SPEED);
          if (ny >= 11'(SCREEN_H)) slot_d[idx_q].active = 1'b0;
          else                     slot_d[idx_q].y      = ny[9:0];
        end
        if (idx_q == IW'(NUM_SLOTS - 1)) state_d = SPAWN;
        else                             idx_d   = idx_q + IW'(1);
      end
      SPAWN: begin
        if (tick) pend_d = 1'b1;
        if (cnt_q == CW'(FIRE_INTERVAL - 1)) begin
          // On failure the counter parks at terminal so the next walk retries.
          if (enemy_alive && free_found &&
              (({1'b0, ep_y} + 11'(SPAWN_DY)) < 11'(SCREEN_H))) begin
            slot_d[free_idx].active = 1'b1;
            slot_d[free_idx].x      = ep_x + 10'(SPAWN_DX);
            slot_d[free_idx].y      = ep_y + 10'(SPAWN_DY);
            cnt_d  = '0;
            fire_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Hits only retire live bullets, so a slot being allocated this cycle survives.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (hit_valid && (hit_slot == IW'(i)) && slot_q[i].active) slot_d[i].active = 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    bullet_pixel_match #(
      .BULLET_W(BULLET_W),
      .BULLET_H(BULLET_H)
    ) u_match (
      .active_i(slot_q[g].active),
      .x_i     (slot_q[g].x),
      .y_i     (slot_q[g].y),
      .pix_x_i (pix_x),
      .pix_y_i (pix_y),
      .match_o (match[g])
    );
    assign eb_x_flat[10*g +: 10] = slot_q[g].x;
    assign eb_y_flat[10*g +: 10] = slot_q[g].y;
    assign eb_active[g]          = slot_q[g].active;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      fire_q  <= 1'b0;
      en_q    <= 1'b0;
      rgb_q   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      fire_q  <= fire_d;
      en_q    <= |match;
      rgb_q   <= (|match) ? BULLET_RGB : 12'h000;
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign fire_pulse       = fire_q;
  assign busy             = (state_q != IDLE);
  assign enemy_bullet_en  = en_q;
  assign enemy_bullet_rgb = rgb_q;

endmodule

// File: tb/tb_enemy_bullet_scheduler.sv
// Bench for enemy_bullet_scheduler: per-walk scoreboard plus directed pixel/reset checks.
module tb_enemy_bullet_scheduler;

  localparam int NS  = 4;
  localparam int FI  = 3;
  localparam int SPD = 2;
  localparam int SH  = 480;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            tick = 1'b0;
  logic            enemy_alive = 1'b0;
  logic            hit_valid = 1'b0;
  logic [1:0]      hit_slot = '0;
  logic [9:0]      ep_x = '0, ep_y = '0, pix_x = '0, pix_y = '0;
  logic [10*NS-1:0] eb_x_flat, eb_y_flat;
  logic [NS-1:0]   eb_active;
  logic            fire_pulse, busy, enemy_bullet_en;
  logic [11:0]     enemy_bullet_rgb;

  enemy_bullet_scheduler #(
    .NUM_SLOTS(NS), .FIRE_INTERVAL(FI), .SPEED(SPD),
    .SCREEN_H(SH), .BULLET_W(4), .BULLET_H(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .ep_x(ep_x), .ep_y(ep_y),
    .enemy_alive(enemy_alive), .hit_valid(hit_valid), .hit_slot(hit_slot),
    .pix_x(pix_x), .pix_y(pix_y), .eb_x_flat(eb_x_flat), .eb_y_flat(eb_y_flat),
    .eb_active(eb_active), .fire_pulse(fire_pulse), .busy(busy),
    .enemy_bullet_en(enemy_bullet_en), .enemy_bullet_rgb(enemy_bullet_rgb)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model of one complete walk.
  typedef struct packed {
    logic [NS-1:0]    act;
    logic [10*NS-1:0] x;
    logic [10*NS-1:0] y;
    logic             fire;
  } exp_t;

  logic [NS-1:0] m_act;
  logic [9:0]    m_x [NS];
  logic [9:0]    m_y [NS];
  int            m_cnt;
  exp_t          sb[$];

  task automatic model_reset();
    m_act = '0;
    m_cnt = 0;
    for (int i = 0; i < NS; i++) begin
      m_x[i] = '0;
      m_y[i] = '0;
    end
  endtask

  function automatic exp_t model_walk(input int hs);
    exp_t e;
    int   fs;
    for (int i = 0; i < NS; i++) begin
      if (m_act[i]) begin
        if (int'(m_y[i]) + SPD >= SH) m_act[i] = 1'b0;
        else                          m_y[i] = m_y[i] + 10'(SPD);
      end
    end
    if (hs >= 0) m_act[hs] = 1'b0;
    e.fire = 1'b0;
    if (m_cnt == FI - 1) begin
      fs = -1;
      for (int i = NS - 1; i >= 0; i--) if (!m_act[i]) fs = i;
      if (enemy_alive && fs >= 0 && int'(ep_y) + 40 < SH) begin
        m_act[fs] = 1'b1;
        m_x[fs]   = ep_x + 10'd23;
        m_y[fs]   = ep_y + 10'd40;
        m_cnt     = 0;
        e.fire    = 1'b1;
      end
    end else begin
      m_cnt++;
    end
    e.act = m_act;
    for (int i = 0; i < NS; i++) begin
      e.x[10*i +: 10] = m_x[i];
      e.y[10*i +: 10] = m_y[i];
    end
    return e;
  endfunction

  // Monitor: each busy falling edge outside reset retires one expected walk.
  int   n_walks = 0;
  logic prev_busy = 1'b0;
  exp_t mon_e;
  initial forever begin
    @(negedge clk);
    if (rst_n && prev_busy && !busy) begin
      n_walks++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        mon_e = sb.pop_front();
        chk("walk_active", 64'(eb_active), 64'(mon_e.act));
        chk("walk_fire", 64'(fire_pulse), 64'(mon_e.fire));
        for (int i = 0; i < NS; i++) begin
          if (mon_e.act[i]) begin
            chk("walk_x", 64'(eb_x_flat[10*i +: 10]), 64'(mon_e.x[10*i +: 10]));
            chk("walk_y", 64'(eb_y_flat[10*i +: 10]), 64'(mon_e.y[10*i +: 10]));
          end
        end
      end
    end
    prev_busy = busy;
  end

  task automatic do_tick(input int hit_c, input int hit_s, input bit extra);
    exp_t e1, e2;
    int   win;
    logic exp_busy, exp_fire;
    e1 = model_walk(hit_c > 0 ? hit_s : -1);
    e2 = '0;
    if (extra) e2 = model_walk(-1);
    sb.push_back(e1);
    if (extra) sb.push_back(e2);
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    win = extra ? 2*NS + 4 : NS + 3;
    for (int c = 1; c <= win; c++) begin
      @(negedge clk);
      exp_busy = (c <= NS + 1) || (extra && c >= NS + 3 && c <= 2*NS + 3);
      exp_fire = (c == NS + 2) ? e1.fire : ((extra && c == 2*NS + 4) ? e2.fire : 1'b0);
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("fire_timing", 64'(fire_pulse), 64'(exp_fire));
      if (c == hit_c) begin
        hit_valid = 1'b1;
        hit_slot  = 2'(hit_s);
      end
      if (extra && c == 3) tick = 1'b1;
      @(posedge clk); #1;
      hit_valid = 1'b0;
      tick      = 1'b0;
    end
  endtask

  task automatic do_hit(input int s);
    @(posedge clk); #1 hit_valid = 1'b1; hit_slot = 2'(s);
    @(posedge clk); #1 hit_valid = 1'b0;
    m_act[s] = 1'b0;
    @(negedge clk);
    chk("hit_idle", 64'(eb_active), 64'(m_act));
  endtask

  task automatic pix_chk(input int px, input int py, input logic exp_en);
    @(negedge clk);
    pix_x = 10'(px);
    pix_y = 10'(py);
    @(negedge clk);
    chk("pix_en", 64'(enemy_bullet_en), 64'(exp_en));
    chk("pix_rgb", 64'(enemy_bullet_rgb), exp_en ? 64'h0F0 : 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  int w0;

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_active", 64'(eb_active), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fire", 64'(fire_pulse), 64'd0);
    chk("rst_en", 64'(enemy_bullet_en), 64'd0);
    chk("rst_x", 64'(eb_x_flat), 64'd0);
    rst_n = 1'b1;

    // First spawn on the third tick.
    enemy_alive = 1'b1;
    ep_x = 10'd100; ep_y = 10'd50;
    repeat (2) do_tick(0, 0, 1'b0);
    chk("no_early_spawn", 64'(eb_active), 64'd0);
    do_tick(0, 0, 1'b0);
    chk("spawn_active", 64'(eb_active), 64'h1);
    chk("spawn_x", 64'(eb_x_flat[9:0]), 64'd123);
    chk("spawn_y", 64'(eb_y_flat[9:0]), 64'd90);

    // Motion and retirement at the bottom edge.
    ep_x = 10'd300; ep_y = 10'd436;
    repeat (3) do_tick(0, 0, 1'b0);
    chk("low_spawn_y", 64'(eb_y_flat[19:10]), 64'd476);
    do_tick(0, 0, 1'b0);
    chk("move_y", 64'(eb_y_flat[19:10]), 64'd478);
    do_tick(0, 0, 1'b0);
    chk("retire_active", 64'(eb_active[1]), 64'd0);
    chk("retire_x_hold", 64'(eb_x_flat[19:10]), 64'd323);
    chk("retire_y_hold", 64'(eb_y_flat[19:10]), 64'd478);

    // Fill the pool, then a spawn attempt with no free slot.
    ep_x = 10'd100; ep_y = 10'd50;
    repeat (9) do_tick(0, 0, 1'b0);
    chk("pool_full", 64'(eb_active), 64'hF);
    do_tick(0, 0, 1'b0);
    chk("pool_full_hold", 64'(eb_active), 64'hF);
    do_hit(2);
    ep_x = 10'd400; ep_y = 10'd200;
    do_tick(0, 0, 1'b0);
    chk("respawn_active", 64'(eb_active), 64'hF);
    chk("respawn_x", 64'(eb_x_flat[29:20]), 64'd423);
    chk("respawn_y", 64'(eb_y_flat[29:20]), 64'd240);

    // Hit lands in the same cycle MOVE writes slot 1; a second tick arrives mid-walk.
    w0 = n_walks;
    do_tick(2, 1, 1'b1);
    chk("hit_move_slot1", 64'(eb_active[1]), 64'd0);
    chk("pending_walks", 64'(n_walks - w0), 64'd2);
    repeat (3) @(negedge clk);
    chk("no_third_walk", 64'(busy), 64'd0);

    // Pixel rectangle edges around a bullet at (200,300).
    do_hit(0);
    ep_x = 10'd177; ep_y = 10'd260;
    do_tick(0, 0, 1'b0);
    chk("pix_slot_x", 64'(eb_x_flat[9:0]), 64'd200);
    chk("pix_slot_y", 64'(eb_y_flat[9:0]), 64'd300);
    pix_chk(203, 315, 1'b1);
    pix_chk(204, 315, 1'b0);
    pix_chk(203, 316, 1'b0);
    pix_chk(200, 300, 1'b1);
    pix_chk(199, 300, 1'b0);
    pix_chk(203, 315, 1'b1);

    // Reset in the middle of a walk drops everything.
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    @(negedge clk);
    chk("mid_walk_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_active", 64'(eb_active), 64'd0);
    chk("midrst_x", 64'(eb_x_flat), 64'd0);
    chk("midrst_y", 64'(eb_y_flat), 64'd0);
    chk("midrst_en", 64'(enemy_bullet_en), 64'd0);
    chk("midrst_rgb", 64'(enemy_bullet_rgb), 64'd0);
    chk("midrst_fire", 64'(fire_pulse), 64'd0);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    chk("post_rst_idle", 64'(busy), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/enemy_bullet_scheduler.md
Name: enemy_bullet_scheduler

Overview:
- Owns a pool of NUM_SLOTS enemy bullets and sequences their whole lifetime: fire timing, slot allocation, per-tick downward motion, retirement off-screen or on hit, and per-pixel draw enable.
- Sits between the enemy-plane position logic, the collision judge (supplies hit_valid/hit_slot) and the VGA pixel mux.
- Replaces per-bullet free-running movers with one sequencer walking the slots.

Parameters:
- NUM_SLOTS, 4, bullet slots in pool (2..8)
- FIRE_INTERVAL, 60, ticks between spawn attempts (≥1)
- SPEED, 2, pixels moved down per tick (1..15)
- SCREEN_H, 480, visible height; y ≥ SCREEN_H is off-screen
- BULLET_W, 4, bullet width in pixels
- BULLET_H, 16, bullet height in pixels

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle move/frame strobe
- ep_x  in  10  enemy plane x
- ep_y  in  10  enemy plane y
- enemy_alive  in  1  spawning allowed when 1
- hit_valid  in  1  collision strobe
- hit_slot  in  $clog2(NUM_SLOTS)  slot index hit
- pix_x  in  10  current scan x
- pix_y  in  10  current scan y
- eb_x_flat  out  10*NUM_SLOTS  slot x positions, slot i at [10i+9:10i]
- eb_y_flat  out  10*NUM_SLOTS  slot y positions
- eb_active  out  NUM_SLOTS  slot-valid mask
- fire_pulse  out  1  one-cycle strobe on spawn
- busy  out  1  sequencer not IDLE
- enemy_bullet_en  out  1  registered pixel-inside-any-active-bullet
- enemy_bullet_rgb  out  12  12'h0F0 when enemy_bullet_en, else 0

Behaviour:
- Reset (async, rst_n=0): every output 0, all slots inactive, fire_cnt=0, state IDLE, tick_pending=0. Reset mid-sequence abandons the walk; nothing is retained.
- FSM states: IDLE, MOVE, SPAWN.
  - IDLE: on tick or tick_pending, go to MOVE with idx=0 and clear tick_pending.
  - MOVE: one slot per cycle. If active: ny = {1'b0,y}+SPEED (11-bit). If ny ≥ SCREEN_H, clear active (x/y hold). Else y=ny[9:0]. Inactive slots are untouched. Go to SPAWN after idx=NUM_SLOTS-1.
  - SPAWN: if fire_cnt==FIRE_INTERVAL-1, run the spawn attempt. Otherwise fire_cnt++. Then return to IDLE.
- Spawn attempt succeeds only if all three hold: enemy_alive=1, a free slot exists, and {1'b0,ep_y}+40 < SCREEN_H.
  - Success: the lowest-index free slot gets x=ep_x+23 (10-bit wrap) and y=ep_y+40, and becomes active. fire_cnt=0. fire_pulse=1 on the next cycle.
  - Failure: fire_cnt holds at terminal and retries on the next tick.
- Tick arriving while busy sets tick_pending (one deep). Further ticks while pending are dropped.
- Latency: tick sampled at cycle T. MOVE spans T+1..T+NUM_SLOTS. SPAWN is at T+NUM_SLOTS+1. Updated outputs are visible from T+NUM_SLOTS+2. busy=1 for T+1..T+NUM_SLOTS+1.
- Hit handling:
  - hit_valid clears eb_active[hit_slot] on the next edge, in any state.
  - Same cycle as a MOVE write to that slot: the hit wins and the slot ends inactive.
  - Hit on an inactive slot is ignored. This includes the slot being allocated in that SPAWN cycle, so the spawn proceeds.
  - hit_slot ≥ NUM_SLOTS is ignored.
- Pixel enable:
  - A slot matches when active && pix_x ≥ x && pix_x < x+BULLET_W && pix_y ≥ y && pix_y < y+BULLET_H.
  - Comparisons are 11-bit, with no wrap.
  - enemy_bullet_en = OR over all slot matches, registered (1-cycle latency). enemy_bullet_rgb is registered alongside it.

Decomposition:
- Package enemy_bullet_pkg holds:
  - state enum (IDLE/MOVE/SPAWN)
  - SPAWN_DX=23, SPAWN_DY=40
  - BULLET_RGB=12'h0F0
  - default SCREEN_H
- Sub-module bullet_pixel_match: combinational rectangle test per slot, NUM_SLOTS instances feeding the OR/register stage.

Test Plan:
- Reset then idle: rst_n low mid-MOVE → all outputs 0, busy=0 next cycle. No spawn before FIRE_INTERVAL ticks.
- Spawn:
  - Setup: FIRE_INTERVAL=3, ep=(100,50), enemy_alive=1, 3 ticks.
  - Response: slot0 at (123,90), eb_active=4'b0001, fire_pulse exactly once, at T+NUM_SLOTS+2 after the 3rd tick.
- Motion/retire: slot0 y=476, SPEED=2, ticks → y=478, then inactive (480 ≥ SCREEN_H). x unchanged.
- Pool full:
  - Setup: 4 active slots, fire_cnt terminal, 1 tick.
  - Response: no spawn, no fire_pulse.
  - Follow-up: hit_slot=2 then a tick → slot2 respawns at ep+(23,40), fire_pulse=1.
- Hit/move collision: hit_valid, hit_slot=1 in the cycle MOVE writes slot1 → slot1 inactive. Second tick while busy → exactly one extra walk follows.
- Pixel:
  - Setup: slot0 at (200,300), pix=(203,315).
  - Response: enemy_bullet_en=1, rgb=12'h0F0 one cycle later. pix=(204,315) or (203,316) → 0.
